// File: rtl/ps2_led_pkg.sv
// ps2_led_pkg: shared types and constants for the PS/2 lock-key LED bank.
//   ch_state_t : per-channel FSM state encoding
//   PS2_BREAK  : break prefix byte (F0)
//   PS2_EXT    : extended-key prefix byte (E0)
package ps2_led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        HELD = 2'd3
    } ch_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_led_bank_if.sv
// ps2_led_bank_if: scan-code stream in, LED bank out.
//   code_new_updated : one-cycle strobe, check_code holds a new byte
//   check_code       : received scan-code byte
//   clk_300k         : tick enable sampled on clk_2
//   mode_momentary   : per channel, 1 = momentary, 0 = toggle
//   led_clr          : synchronous clear of all LEDs
//   leds             : registered LED outputs
//   led_pulse        : one-cycle pulse when a channel's LED update is visible
// master = byte/control source, slave = LED bank.
interface ps2_led_bank_if #(
    parameter int N_CH = 3
) ();
    logic            code_new_updated;
    logic [7:0]      check_code;
    logic            clk_300k;
    logic [N_CH-1:0] mode_momentary;
    logic            led_clr;
    logic [N_CH-1:0] leds;
    logic [N_CH-1:0] led_pulse;

    modport master (
        output code_new_updated, check_code, clk_300k, mode_momentary, led_clr,
        input  leds, led_pulse
    );

    modport slave (
        input  code_new_updated, check_code, clk_300k, mode_momentary, led_clr,
        output leds, led_pulse
    );
endinterface

// File: rtl/ps2_led_channel.sv
// ps2_led_channel: one lock-key channel (FSM, acceptance counter, LED register).
//   clk_2, reset : clock and synchronous active-high reset
//   make_hit     : make event for this channel's code
//   brk_hit      : break event for this channel's code
//   tick         : acceptance-delay tick enable
//   mode         : 1 = momentary, 0 = toggle (only looked at in FIRE / release)
//   clr          : force LED to 0, suppresses pulse
//   led, pulse   : registered LED and one-cycle update pulse
module ps2_led_channel
    import ps2_led_pkg::*;
#(
    parameter int DELAY_TICKS = 151,
    parameter int CNT_W       = 12
) (
    input  logic clk_2,
    input  logic reset,
    input  logic make_hit,
    input  logic brk_hit,
    input  logic tick,
    input  logic mode,
    input  logic clr,
    output logic led,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DLY     = CNT_W'(DELAY_TICKS);

    ch_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             led_n, pulse_n;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            led   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            led   <= led_n;
            pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        led_n   = led;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (make_hit) begin
                    state_n = ARM;
                    cnt_n   = '0;
                end
            end
            ARM: begin
                if (tick && (cnt != CNT_MAX))
                    cnt_n = cnt + 1'b1;
                // A release arriving while still armed wins over firing,
                // so a short tap never touches the LED.
                if (brk_hit)
                    state_n = IDLE;
                else if (cnt >= DLY)
                    state_n = FIRE;
            end
            FIRE: begin
                led_n   = mode ? 1'b1 : ~led;
                pulse_n = 1'b1;
                state_n = HELD;
            end
            HELD: begin
                if (brk_hit) begin
                    state_n = IDLE;
                    if (mode) begin
                        led_n   = 1'b0;
                        pulse_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Clear overrides any LED update this cycle and hides its pulse.
        if (clr) begin
            led_n   = 1'b0;
            pulse_n = 1'b0;
        end
    end

endmodule

// File: rtl/ps2_led_bank.sv
// ps2_led_bank: multi-channel PS/2 lock-key LED controller.
//   clk_2 : sole clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : ps2_led_bank_if.slave (scan-code stream, tick, modes, clear, LEDs)
// Decodes the byte stream into per-key make/break events (F0 prefix marks a
// break, E0 prefix is transparent) and feeds one channel per configured code.
module ps2_led_bank
    import ps2_led_pkg::*;
#(
    parameter int                N_CH        = 3,
    parameter logic [8*N_CH-1:0] KEYCODES    = 24'h7E_58_77,
    parameter int                DELAY_TICKS = 151,
    parameter int                CNT_W       = 12
) (
    input  logic          clk_2,
    input  logic          reset,
    ps2_led_bank_if.slave bus
);

    if ((2 ** CNT_W) <= DELAY_TICKS) begin : g_cnt_w_check
        $error("ps2_led_bank: CNT_W too narrow for DELAY_TICKS");
    end

    logic            is_break;
    logic            is_event;
    logic            brk_pend;
    logic [N_CH-1:0] make_hit;
    logic [N_CH-1:0] brk_hit;
    logic [N_CH-1:0] leds_w;
    logic [N_CH-1:0] pulse_w;

    assign is_break = bus.code_new_updated && (bus.check_code == PS2_BREAK);
    // E0 is neither a break prefix nor a key: it must not disturb brk_pend.
    assign is_event = bus.code_new_updated
                   && (bus.check_code != PS2_BREAK)
                   && (bus.check_code != PS2_EXT);

    always_ff @(posedge clk_2) begin
        if (reset)
            brk_pend <= 1'b0;
        else if (is_break)
            brk_pend <= 1'b1;
        else if (is_event)
            brk_pend <= 1'b0;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic own;
        assign own         = is_event && (bus.check_code == KEYCODES[8*i +: 8]);
        assign make_hit[i] = own && !brk_pend;
        assign brk_hit[i]  = own &&  brk_pend;

        ps2_led_channel #(
            .DELAY_TICKS (DELAY_TICKS),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk_2    (clk_2),
            .reset    (reset),
            .make_hit (make_hit[i]),
            .brk_hit  (brk_hit[i]),
            .tick     (bus.clk_300k),
            .mode     (bus.mode_momentary[i]),
            .clr      (bus.led_clr),
            .led      (leds_w[i]),
            .pulse    (pulse_w[i])
        );
    end

    assign bus.leds      = leds_w;
    assign bus.led_pulse = pulse_w;

endmodule

// File: tb/tb_ps2_led_bank.sv
// tb_ps2_led_bank: directed scenarios plus randomized traffic against a
// scheduled-event reference model for the default 3-channel bank, and a
// directed check of a 5-channel, short-delay instance.
module tb_ps2_led_bank;

    localparam int          D    = 151;
    localparam logic [23:0] KEYS = 24'h7E_58_77;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    always #5 clk_2 = ~clk_2;

    ps2_led_bank_if #(.N_CH(3)) bus  ();
    ps2_led_bank_if #(.N_CH(5)) bus5 ();

    ps2_led_bank dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    ps2_led_bank #(
        .N_CH        (5),
        .KEYCODES    (40'h2E_1E_26_25_2E),
        .DELAY_TICKS (3),
        .CNT_W       (2)
    ) dut5 (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pressed key counts ticks from the cycle after its
    // make; when the D-th tick lands in cycle T the LED update is applied by
    // the edge of cycle T+2. A break before that edge cancels the press.
    bit          m_down   [3];
    bit          m_fired  [3];
    int          m_ticks  [3];
    int          m_fire_at[3];
    bit          m_brk;
    int          m_n = 0;
    logic [2:0]  exp_leds  = '0;
    logic [2:0]  exp_pulse = '0;

    task automatic model_step();
        logic [7:0] c;
        bit         ev;
        c  = bus.check_code;
        ev = bus.code_new_updated && (c != 8'hF0) && (c != 8'hE0);
        exp_pulse = '0;
        if (reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                m_down[ch] = 0; m_fired[ch] = 0; m_ticks[ch] = 0; m_fire_at[ch] = -1;
            end
            exp_leds = '0;
            m_brk    = 0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                bit own, mk, bk;
                own = ev && (c == KEYS[8*ch +: 8]);
                mk  = own && !m_brk;
                bk  = own &&  m_brk;
                if (m_fire_at[ch] == m_n) begin
                    exp_leds[ch]  = bus.mode_momentary[ch] ? 1'b1 : ~exp_leds[ch];
                    exp_pulse[ch] = 1'b1;
                    m_fire_at[ch] = -1;
                    m_fired[ch]   = 1;
                end else if (m_down[ch] && bk) begin
                    if (m_fired[ch] && bus.mode_momentary[ch]) begin
                        exp_leds[ch]  = 1'b0;
                        exp_pulse[ch] = 1'b1;
                    end
                    m_down[ch] = 0; m_fired[ch] = 0; m_fire_at[ch] = -1;
                end else if (!m_down[ch] && mk) begin
                    m_down[ch] = 1; m_fired[ch] = 0; m_ticks[ch] = 0; m_fire_at[ch] = -1;
                end else if (m_down[ch] && !m_fired[ch] && m_fire_at[ch] < 0 && bus.clk_300k) begin
                    m_ticks[ch]++;
                    if (m_ticks[ch] == D) m_fire_at[ch] = m_n + 2;
                end
                if (bus.led_clr) begin
                    exp_leds[ch]  = 1'b0;
                    exp_pulse[ch] = 1'b0;
                end
            end
            if (bus.code_new_updated && c == 8'hF0) m_brk = 1;
            else if (ev)                            m_brk = 0;
        end
        m_n++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_2);
        #1;
        bus.code_new_updated  = 1'b0;
        bus5.code_new_updated = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic send(input logic [7:0] b);
        bus.check_code       = b;
        bus.code_new_updated = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        n_checks++;
        if (bus.leds !== 3'b000 || bus.led_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state leds=%b pulse=%b expected 000/000", bus.leds, bus.led_pulse);
        end
        n_checks++;
        if (bus5.leds !== 5'b0 || bus5.led_pulse !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state5 leds=%b pulse=%b expected 0/0", bus5.leds, bus5.led_pulse);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_toggle();
        bus.mode_momentary = 3'b000;
        bus.clk_300k       = 1'b1;
        send(8'h77);
        idle(152);
        n_checks++;
        if (bus.leds !== 3'b000) begin
            n_fail++; $display("FAIL toggle_early leds=%b expected 000", bus.leds);
        end
        idle(1);
        n_checks++;
        if (bus.leds !== 3'b001 || bus.led_pulse !== 3'b001) begin
            n_fail++; $display("FAIL toggle_fire leds=%b pulse=%b expected 001/001", bus.leds, bus.led_pulse);
        end
        idle(1);
        n_checks++;
        if (bus.led_pulse !== 3'b000 || bus.leds !== 3'b001) begin
            n_fail++; $display("FAIL toggle_pulse_len leds=%b pulse=%b expected 001/000", bus.leds, bus.led_pulse);
        end
        send(8'hF0); send(8'h77);
        send(8'h77);
        idle(153);
        n_checks++;
        if (bus.leds !== 3'b000 || bus.led_pulse !== 3'b001) begin
            n_fail++; $display("FAIL toggle_second leds=%b pulse=%b expected 000/001", bus.leds, bus.led_pulse);
        end
        send(8'hF0); send(8'h77);
        idle(2);
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        send(8'h58);
        idle(50);
        send(8'hF0); send(8'h58);
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (bus.leds[1] !== 1'b0 || bus.led_pulse[1] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL glitch_reject bad_cycles=%0d expected 0", bad);
        end
        send(8'h58);
        idle(152);
        n_checks++;
        if (bus.leds !== 3'b000) begin
            n_fail++; $display("FAIL glitch_rearm_early leds=%b expected 000", bus.leds);
        end
        idle(1);
        n_checks++;
        if (bus.leds !== 3'b010 || bus.led_pulse !== 3'b010) begin
            n_fail++; $display("FAIL glitch_rearm_fire leds=%b pulse=%b expected 010/010", bus.leds, bus.led_pulse);
        end
        send(8'hF0); send(8'h58);
        bus.led_clr = 1'b1; cycle(); bus.led_clr = 1'b0;
        n_checks++;
        if (bus.leds !== 3'b000) begin
            n_fail++; $display("FAIL led_clr leds=%b expected 000", bus.leds);
        end
    endtask

    task automatic test_momentary();
        bus.mode_momentary = 3'b100;
        send(8'h7E);
        idle(153);
        n_checks++;
        if (bus.leds !== 3'b100 || bus.led_pulse !== 3'b100) begin
            n_fail++; $display("FAIL mom_fire leds=%b pulse=%b expected 100/100", bus.leds, bus.led_pulse);
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h7E);
            idle(3);
            n_checks++;
            if (bus.leds !== 3'b100 || bus.led_pulse !== 3'b000) begin
                n_fail++; $display("FAIL mom_repeat%0d leds=%b pulse=%b expected 100/000", i, bus.leds, bus.led_pulse);
            end
        end
        send(8'hF0); send(8'h7E);
        n_checks++;
        if (bus.leds !== 3'b000) begin
            n_fail++; $display("FAIL mom_release leds=%b expected 000", bus.leds);
        end
        bus.mode_momentary = 3'b000;
        idle(2);
    endtask

    task automatic test_per_key_break();
        send(8'h77); send(8'h58);
        idle(153);
        n_checks++;
        if (bus.leds !== 3'b011) begin
            n_fail++; $display("FAIL pkb_both_held leds=%b expected 011", bus.leds);
        end
        send(8'hF0); send(8'h58);
        send(8'h77);
        send(8'h58);
        idle(152);
        n_checks++;
        if (bus.leds !== 3'b011) begin
            n_fail++; $display("FAIL pkb_ch0_kept leds=%b expected 011", bus.leds);
        end
        idle(1);
        n_checks++;
        if (bus.leds !== 3'b001 || bus.led_pulse !== 3'b010) begin
            n_fail++; $display("FAIL pkb_ch1_refire leds=%b pulse=%b expected 001/010", bus.leds, bus.led_pulse);
        end
        send(8'hF0); send(8'hE0); send(8'h77);
        send(8'h77);
        idle(152);
        n_checks++;
        if (bus.leds !== 3'b001) begin
            n_fail++; $display("FAIL pkb_ext_early leds=%b expected 001", bus.leds);
        end
        idle(1);
        n_checks++;
        if (bus.leds !== 3'b000 || bus.led_pulse !== 3'b001) begin
            n_fail++; $display("FAIL pkb_ext_release leds=%b pulse=%b expected 000/001", bus.leds, bus.led_pulse);
        end
        send(8'hF0); send(8'h77);
        send(8'hF0); send(8'h58);
        idle(2);
    endtask

    task automatic test_reset_clear();
        int bad;
        bad = 0;
        send(8'h77);
        idle(50);
        reset = 1'b1; cycle(); reset = 1'b0;
        n_checks++;
        if (bus.leds !== 3'b000 || bus.led_pulse !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset leds=%b pulse=%b expected 000/000", bus.leds, bus.led_pulse);
        end
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (bus.leds !== 3'b000 || bus.led_pulse !== 3'b000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_no_fire bad_cycles=%0d expected 0", bad);
        end
        send(8'h58);
        idle(152);
        bus.led_clr = 1'b1; cycle(); bus.led_clr = 1'b0;
        n_checks++;
        if (bus.leds !== 3'b000 || bus.led_pulse !== 3'b000) begin
            n_fail++; $display("FAIL clr_at_fire leds=%b pulse=%b expected 000/000", bus.leds, bus.led_pulse);
        end
        idle(1);
        n_checks++;
        if (bus.led_pulse !== 3'b000) begin
            n_fail++; $display("FAIL clr_pulse_suppressed pulse=%b expected 000", bus.led_pulse);
        end
        bad = 0;
        send(8'h58);
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (bus.leds[1] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL clr_fsm_held bad_cycles=%0d expected 0", bad);
        end
        send(8'hF0); send(8'h58);
        send(8'h58);
        idle(153);
        n_checks++;
        if (bus.leds !== 3'b010) begin
            n_fail++; $display("FAIL clr_then_release leds=%b expected 010", bus.leds);
        end
        send(8'hF0); send(8'h58);
        bus.led_clr = 1'b1; cycle(); bus.led_clr = 1'b0;
    endtask

    task automatic test_param();
        int         tk;
        int         fire_edge;
        int         bad;
        logic [4:0] want;
        tk = 0; fire_edge = 1000; bad = 0;
        bus5.mode_momentary   = 5'b00000;
        bus5.clk_300k         = 1'b0;
        bus5.check_code       = 8'h2E;
        bus5.code_new_updated = 1'b1;
        cycle();
        for (int k = 1; k <= 30; k++) begin
            bus5.clk_300k = ((k % 4) == 3);
            if (bus5.clk_300k) begin
                tk++;
                if (tk == 3) fire_edge = k + 2;
            end
            cycle();
            want = (k >= fire_edge) ? 5'b10001 : 5'b00000;
            n_checks++;
            if (bus5.leds !== want || bus5.led_pulse !== ((k == fire_edge) ? 5'b10001 : 5'b00000)) begin
                n_fail++;
                $display("FAIL param_fire k=%0d leds=%b pulse=%b expected leds=%b", k, bus5.leds, bus5.led_pulse, want);
            end
        end
        n_checks++;
        if (fire_edge != 13) begin
            n_fail++; $display("FAIL param_latency fire_edge=%0d expected 13", fire_edge);
        end
        bus5.clk_300k = 1'b1;
        bus5.check_code = 8'hF0; bus5.code_new_updated = 1'b1; cycle();
        bus5.check_code = 8'h2E; bus5.code_new_updated = 1'b1; cycle();
        idle(3);
        n_checks++;
        if (bus5.leds !== 5'b10001) begin
            n_fail++; $display("FAIL param_release leds=%b expected 10001", bus5.leds);
        end
    endtask

    task automatic test_random(input int n_cyc, input bit always_tick);
        logic [7:0] pool [5];
        pool[0] = 8'h77; pool[1] = 8'h58; pool[2] = 8'h7E; pool[3] = 8'hF0; pool[4] = 8'hE0;
        for (int i = 0; i < n_cyc; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                int r;
                r = $urandom_range(0, 9);
                bus.check_code = (r < 5) ? pool[r] : ((r < 8) ? pool[3] : 8'($urandom));
                bus.code_new_updated = 1'b1;
            end
            bus.clk_300k       = always_tick ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.mode_momentary = 3'($urandom);
            bus.led_clr        = ($urandom_range(0, 499) == 0);
            reset              = ($urandom_range(0, 2999) == 0);
            cycle();
            n_checks++;
            if (bus.leds !== exp_leds) begin
                n_fail++; $display("FAIL rand_leds cyc=%0d leds=%b expected %b", i, bus.leds, exp_leds);
            end
            n_checks++;
            if (bus.led_pulse !== exp_pulse) begin
                n_fail++; $display("FAIL rand_pulse cyc=%0d pulse=%b expected %b", i, bus.led_pulse, exp_pulse);
            end
        end
        reset       = 1'b0;
        bus.led_clr = 1'b0;
    endtask

    initial begin
        bus.code_new_updated  = 1'b0;
        bus.check_code        = 8'h00;
        bus.clk_300k          = 1'b1;
        bus.mode_momentary    = 3'b000;
        bus.led_clr           = 1'b0;
        bus5.code_new_updated = 1'b0;
        bus5.check_code       = 8'h00;
        bus5.clk_300k         = 1'b0;
        bus5.mode_momentary   = 5'b00000;
        bus5.led_clr          = 1'b0;

        test_reset();
        test_toggle();
        test_glitch();
        test_momentary();
        test_per_key_break();
        test_reset_clear();
        test_param();
        test_random(12000, 1'b0);
        test_random(8000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
